pad_out_seq: RTL and testbench

//  Contention-safe output sequencer directly upstream of one output pad cell.

---
 rtl/pad_out_seq_pkg.sv | 26 ++
 rtl/pad_out_seq_sync_2ff.sv | 30 +++
 rtl/pad_out_seq.sv | 132 +++++++++++++
 tb/tb_pad_out_seq.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/pad_out_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pad_out_seq_pkg
// Description : Shared types for the contention-safe pad output sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package pad_out_seq_pkg;

    // The pending-request struct is sized by this width; instances must use
    // a matching PADATTR.
    localparam int PADATTR_W = 16;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        TURN_OFF = 2'd1,
        TURN_ON  = 2'd2
    } pad_seq_state_e;

    typedef struct packed {
        logic                 val;
        logic                 oe;
        logic [PADATTR_W-1:0] attr;
    } pad_req_t;

endpackage
`default_nettype wire

// File: rtl/pad_out_seq_sync_2ff.sv
`default_nettype none
// ============================================================================
// Module      : sync_2ff
// Description : Single-bit two-flop synchroniser, async active-high reset to 0.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule
`default_nettype wire

// File: rtl/pad_out_seq.sv
`default_nettype none
// ============================================================================
// Module      : pad_out_seq
// Description : Orders pad value/OE/attribute updates so the pad never drives
//               while direction or attributes switch; resyncs pad readback.
// Revision    : 1.0 - initial release
// ============================================================================
module pad_out_seq
    import pad_out_seq_pkg::*;
#(
    parameter int                 PADATTR     = PADATTR_W,
    parameter int                 TURN_CYCLES = 2,
    parameter logic [PADATTR-1:0] ATTR_RESET  = '0
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               req_valid_i,
    output logic               req_ready_o,
    input  logic               req_val_i,
    input  logic               req_oe_i,
    input  logic [PADATTR-1:0] req_attr_i,
    output logic               busy_o,
    output logic               pad_in_o,
    output logic               pad_oe_o,
    output logic [PADATTR-1:0] pad_attributes_o,
    input  logic               pad_out_i,
    output logic               rd_val_o
);

    localparam int               CNT_W  = $clog2(TURN_CYCLES + 1);
    localparam logic [CNT_W-1:0] C_TURN = CNT_W'(TURN_CYCLES);
    localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);

    pad_seq_state_e     r_state, w_state_nxt;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
    pad_req_t           r_pend, w_pend_nxt;
    logic               r_val, w_val_nxt;
    logic               r_oe, w_oe_nxt;
    logic [PADATTR-1:0] r_attr, w_attr_nxt;
    logic               w_accept;

    assign req_ready_o      = (r_state == IDLE);
    assign busy_o           = (r_state != IDLE);
    assign w_accept         = req_valid_i && req_ready_o;
    assign pad_in_o         = r_val;
    assign pad_oe_o         = r_oe;
    assign pad_attributes_o = r_attr;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_pend  <= '0;
            r_val   <= 1'b0;
            r_oe    <= 1'b0;
            r_attr  <= ATTR_RESET;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_pend  <= w_pend_nxt;
            r_val   <= w_val_nxt;
            r_oe    <= w_oe_nxt;
            r_attr  <= w_attr_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_pend_nxt  = r_pend;
        w_val_nxt   = r_val;
        w_oe_nxt    = r_oe;
        w_attr_nxt  = r_attr;

        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_pend_nxt.val  = req_val_i;
                    w_pend_nxt.oe   = req_oe_i;
                    w_pend_nxt.attr = req_attr_i;
                    if (!r_oe) begin
                        // Pad is not driving: value and attributes may move now.
                        w_val_nxt  = req_val_i;
                        w_attr_nxt = req_attr_i;
                        if (req_oe_i) begin
                            w_state_nxt = TURN_ON;
                            w_cnt_nxt   = C_TURN;
                        end
                    end else if (!req_oe_i || (req_attr_i != r_attr)) begin
                        w_oe_nxt    = 1'b0;
                        w_state_nxt = TURN_OFF;
                        w_cnt_nxt   = C_TURN;
                    end else begin
                        w_val_nxt = req_val_i;
                    end
                end
            end
            TURN_OFF: begin
                w_cnt_nxt = r_cnt - C_ONE;
                if (r_cnt == C_ONE) begin
                    w_val_nxt  = r_pend.val;
                    w_attr_nxt = r_pend.attr;
                    if (r_pend.oe) begin
                        w_state_nxt = TURN_ON;
                        w_cnt_nxt   = C_TURN;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            TURN_ON: begin
                w_cnt_nxt = r_cnt - C_ONE;
                if (r_cnt == C_ONE) begin
                    w_oe_nxt    = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    sync_2ff u_rd_sync (
        .clk (clk_i),
        .rst (rst_i),
        .i_d (pad_out_i),
        .o_q (rd_val_o)
    );

endmodule
`default_nettype wire

// File: tb/tb_pad_out_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_pad_out_seq
// Description : Self-checking bench: vector table, directed corners, random run.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pad_out_seq;

    localparam int TC = 2;

    logic        clk_i       = 1'b0;
    logic        rst_i       = 1'b1;
    logic        req_valid_i = 1'b0;
    logic        req_val_i   = 1'b0;
    logic        req_oe_i    = 1'b0;
    logic [15:0] req_attr_i  = '0;
    logic        pad_out_i   = 1'b0;
    logic        req_ready_o, busy_o, pad_in_o, pad_oe_o, rd_val_o;
    logic [15:0] pad_attributes_o;

    always #5 clk_i = ~clk_i;

    pad_out_seq #(.PADATTR(16), .TURN_CYCLES(TC), .ATTR_RESET(16'h0000)) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .req_valid_i      (req_valid_i),
        .req_ready_o      (req_ready_o),
        .req_val_i        (req_val_i),
        .req_oe_i         (req_oe_i),
        .req_attr_i       (req_attr_i),
        .busy_o           (busy_o),
        .pad_in_o         (pad_in_o),
        .pad_oe_o         (pad_oe_o),
        .pad_attributes_o (pad_attributes_o),
        .pad_out_i        (pad_out_i),
        .rd_val_o         (rd_val_o)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Timeline model: each accepted request schedules the edges at which the
    // pad sees new value/attr and OE rise, and the edge where ready returns.
    int          cyc = 0;
    int          m_free = 0, m_apply = -1, m_rise = -1;
    logic        m_val = 0, m_oe = 0, m_acc = 0, ap_val = 0;
    logic [15:0] m_attr = '0, ap_attr = '0;
    logic        hist[$];

    initial forever begin
        @(posedge clk_i or posedge rst_i);
        if (rst_i) begin
            m_val = 0; m_oe = 0; m_attr = '0; m_acc = 0;
            m_free = cyc; m_apply = -1; m_rise = -1;
            hist.delete();
        end else begin
            cyc = cyc + 1;
            if (cyc == m_apply) begin m_val = ap_val; m_attr = ap_attr; end
            if (cyc == m_rise) m_oe = 1'b1;
            m_acc = req_valid_i && (cyc - 1 >= m_free);
            if (m_acc) begin
                if (!m_oe) begin
                    m_val = req_val_i; m_attr = req_attr_i;
                    m_free = req_oe_i ? cyc + TC : cyc;
                    if (req_oe_i) m_rise = cyc + TC;
                end else if (!req_oe_i || req_attr_i != m_attr) begin
                    m_oe = 1'b0;
                    m_apply = cyc + TC; ap_val = req_val_i; ap_attr = req_attr_i;
                    m_free = req_oe_i ? cyc + 2 * TC : cyc + TC;
                    if (req_oe_i) m_rise = cyc + 2 * TC;
                end else begin
                    m_val = req_val_i;
                end
            end
            hist.push_back(pad_out_i);
            if (hist.size() > 4) void'(hist.pop_front());
        end
    end

    task automatic check_model();
        logic exp_rd;
        exp_rd = (hist.size() >= 2) ? hist[hist.size()-2] : 1'b0;
        chk("m_pad_in", pad_in_o, m_val);
        chk("m_pad_oe", pad_oe_o, m_oe);
        chk("m_attr",   pad_attributes_o, m_attr);
        chk("m_ready",  req_ready_o, cyc >= m_free);
        chk("m_busy",   busy_o, cyc < m_free);
        chk("m_rd_val", rd_val_o, exp_rd);
    endtask

    ap_attr_stable: assert property (@(posedge clk_i) disable iff (rst_i)
        !$stable(pad_attributes_o) |-> (!pad_oe_o && !$past(pad_oe_o)))
        else begin
            errors++;
            $display("FAIL attr_invariant: attr changed with oe=%0b", pad_oe_o);
        end

    typedef struct {
        logic        valid, val, oe;
        logic [15:0] attr;
        logic        e_in, e_oe;
        logic [15:0] e_attr;
        logic        e_rdy;
    } vec_t;

    function automatic vec_t mk(input logic v, input logic d, input logic o, input logic [15:0] a,
                                input logic ei, input logic eo, input logic [15:0] ea, input logic er);
        vec_t r;
        r.valid = v; r.val = d; r.oe = o; r.attr = a;
        r.e_in = ei; r.e_oe = eo; r.e_attr = ea; r.e_rdy = er;
        return r;
    endfunction

    vec_t tbl[27];

    initial begin
        // Enable, attr swap, fast path, disable, backpressure during TURN_ON.
        tbl[0]  = mk(1, 1, 1, 16'h3, 1, 0, 16'h3, 0);
        tbl[1]  = mk(0, 1, 1, 16'h3, 1, 0, 16'h3, 0);
        tbl[2]  = mk(0, 1, 1, 16'h3, 1, 1, 16'h3, 1);
        tbl[3]  = mk(1, 1, 1, 16'h5, 1, 0, 16'h3, 0);
        tbl[4]  = mk(0, 1, 1, 16'h5, 1, 0, 16'h3, 0);
        tbl[5]  = mk(0, 1, 1, 16'h5, 1, 0, 16'h5, 0);
        tbl[6]  = mk(0, 1, 1, 16'h5, 1, 0, 16'h5, 0);
        tbl[7]  = mk(0, 1, 1, 16'h5, 1, 1, 16'h5, 1);
        for (int i = 8; i < 16; i++)
            tbl[i] = mk(1, i[0], 1, 16'h5, i[0], 1, 16'h5, 1);
        tbl[16] = mk(1, 0, 0, 16'h5, 1, 0, 16'h5, 0);
        tbl[17] = mk(0, 0, 0, 16'h5, 1, 0, 16'h5, 0);
        tbl[18] = mk(0, 0, 0, 16'h5, 0, 0, 16'h5, 1);
        tbl[19] = mk(1, 1, 1, 16'h5, 1, 0, 16'h5, 0);
        tbl[20] = mk(1, 0, 1, 16'h9, 1, 0, 16'h5, 0);
        tbl[21] = mk(1, 0, 1, 16'h9, 1, 1, 16'h5, 1);
        tbl[22] = mk(1, 0, 1, 16'h9, 1, 0, 16'h5, 0);
        tbl[23] = mk(0, 0, 1, 16'h9, 1, 0, 16'h5, 0);
        tbl[24] = mk(0, 0, 1, 16'h9, 0, 0, 16'h9, 0);
        tbl[25] = mk(0, 0, 1, 16'h9, 0, 0, 16'h9, 0);
        tbl[26] = mk(0, 0, 1, 16'h9, 0, 1, 16'h9, 1);

        repeat (3) @(negedge clk_i);
        chk("rst_pad_in", pad_in_o, 1'b0);
        chk("rst_pad_oe", pad_oe_o, 1'b0);
        chk("rst_attr",   pad_attributes_o, 16'h0000);
        chk("rst_rd_val", rd_val_o, 1'b0);
        rst_i = 1'b0;
        #1;
        chk("post_rst_ready", req_ready_o, 1'b1);
        chk("post_rst_busy",  busy_o, 1'b0);

        for (int i = 0; i < 27; i++) begin
            req_valid_i = tbl[i].valid; req_val_i = tbl[i].val;
            req_oe_i    = tbl[i].oe;    req_attr_i = tbl[i].attr;
            @(negedge clk_i);
            chk($sformatf("tbl%0d_in", i),   pad_in_o, tbl[i].e_in);
            chk($sformatf("tbl%0d_oe", i),   pad_oe_o, tbl[i].e_oe);
            chk($sformatf("tbl%0d_attr", i), pad_attributes_o, tbl[i].e_attr);
            chk($sformatf("tbl%0d_rdy", i),  req_ready_o, tbl[i].e_rdy);
            check_model();
        end
        req_valid_i = 1'b0;

        // Readback: two edges of latency.
        pad_out_i = 1'b1;
        @(negedge clk_i);
        chk("rd_after_1", rd_val_o, 1'b0);
        @(negedge clk_i);
        chk("rd_after_2", rd_val_o, 1'b1);
        check_model();

        // Reset while in TURN_OFF.
        req_valid_i = 1'b1; req_val_i = 1'b1; req_oe_i = 1'b0; req_attr_i = 16'h9;
        @(negedge clk_i);
        req_valid_i = 1'b0;
        chk("toff_oe",   pad_oe_o, 1'b0);
        chk("toff_busy", busy_o, 1'b1);
        @(posedge clk_i);
        #2;
        rst_i = 1'b1;
        #1;
        chk("midrst_oe",   pad_oe_o, 1'b0);
        chk("midrst_in",   pad_in_o, 1'b0);
        chk("midrst_attr", pad_attributes_o, 16'h0000);
        chk("midrst_rd",   rd_val_o, 1'b0);
        @(negedge clk_i);
        @(negedge clk_i);
        chk("rst_hold_oe",   pad_oe_o, 1'b0);
        chk("rst_hold_attr", pad_attributes_o, 16'h0000);
        rst_i = 1'b0;
        #1;
        chk("rst2_ready", req_ready_o, 1'b1);
        chk("rst2_busy",  busy_o, 1'b0);

        // Random requests under the valid/ready hold rule.
        for (int k = 0; k < 600; k++) begin
            if (!req_valid_i || m_acc) begin
                int r;
                req_valid_i = ($urandom_range(0, 9) < 6);
                req_val_i   = 1'($urandom_range(0, 1));
                req_oe_i    = ($urandom_range(0, 3) != 0);
                r = $urandom_range(0, 9);
                if (r < 6)      req_attr_i = m_attr;
                else if (r < 8) req_attr_i = (r == 6) ? 16'h3 : 16'h5;
                else            req_attr_i = 16'($urandom);
            end
            pad_out_i = 1'($urandom_range(0, 1));
            @(negedge clk_i);
            check_model();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
